// File: rtl/rsa_pkg.sv
// Shared RSA types: exponentiation FSM state encoding and default operand sizes.
package rsa_pkg;

    localparam int DEF_WIDTH = 2048;
    localparam int DEF_EXP_W = 2048;

    typedef enum logic [2:0] {
        IDLE,
        TO_X,
        TO_ONE,
        SQR,
        MUL,
        FROM,
        FIN
    } exp_state_e;

    function automatic logic is_mm_state(input exp_state_e s);
        return (s == TO_X) || (s == TO_ONE) || (s == SQR) || (s == MUL) || (s == FROM);
    endfunction

endpackage

// File: rtl/mont_mm_issue.sv
// Launch/wait/capture handshake toward the external Montgomery multiplier.
// One request pulse latches the operands and fires mm_start; ack pulses the cycle after mm_done.
module mont_mm_issue
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mm_done_i,
    input  logic [WIDTH-1:0] mm_result_i,
    output logic             mm_start_o,
    output logic [WIDTH-1:0] mm_a_o,
    output logic [WIDTH-1:0] mm_b_o,
    output logic             ack_o,
    output logic [WIDTH-1:0] prod_o
);

    logic             start_q;
    logic             wait_q;
    logic             ack_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            wait_q  <= 1'b0;
            ack_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            start_q <= req_i;
            ack_q   <= 1'b0;
            if (req_i) begin
                a_q    <= a_i;
                b_q    <= b_i;
                wait_q <= 1'b1;
            // a done coincident with the launch pulse cannot belong to this multiply
            end else if (wait_q && mm_done_i && !start_q) begin
                wait_q <= 1'b0;
                ack_q  <= 1'b1;
                prod_q <= mm_result_i;
            end
        end
    end

    assign mm_start_o = start_q;
    assign mm_a_o     = a_q;
    assign mm_b_o     = b_q;
    assign ack_o      = ack_q;
    assign prod_o     = prod_q;

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod n on a shared Montgomery multiplier.
// Build option MONT_EXP_CONST_TIME_EN: run MUL for every exponent bit, discarding products of zero bits.
module mont_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int EXP_W = DEF_EXP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exp,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] r2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    input  logic             mm_done,
    input  logic [WIDTH-1:0] mm_result
);

    localparam int               IDX_W   = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

`ifdef MONT_EXP_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    exp_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [EXP_W-1:0] e_q;
    logic [WIDTH-1:0] x_q, n_q, r2_q, xm_q, acc_q, result_q;
    logic             busy_q, done_q, iss_q;

    logic             req;
    logic             ack;
    logic [WIDTH-1:0] op_a, op_b, prod;
    logic             bit_set, last_bit;

    assign bit_set  = e_q[idx_q];
    assign last_bit = (idx_q == '0);
    assign req      = is_mm_state(state_q) && !iss_q;

    always_comb begin
        op_a = acc_q;
        op_b = acc_q;
        unique case (state_q)
            TO_X:    begin op_a = x_q; op_b = r2_q; end
            TO_ONE:  begin op_a = ONE; op_b = r2_q; end
            MUL:     op_b = xm_q;
            FROM:    op_b = ONE;
            default: ;
        endcase
    end

    mont_mm_issue #(.WIDTH(WIDTH)) u_issue (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .a_i         (op_a),
        .b_i         (op_b),
        .mm_done_i   (mm_done),
        .mm_result_i (mm_result),
        .mm_start_o  (mm_start),
        .mm_a_o      (mm_a),
        .mm_b_o      (mm_b),
        .ack_o       (ack),
        .prod_o      (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            e_q      <= '0;
            x_q      <= '0;
            n_q      <= '0;
            r2_q     <= '0;
            xm_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            iss_q    <= 1'b0;
        end else begin
            if (req) iss_q <= 1'b1;
            if (ack) iss_q <= 1'b0;
            unique case (state_q)
                IDLE: if (start) begin
                    x_q     <= base;
                    e_q     <= exp;
                    n_q     <= n;
                    r2_q    <= r2;
                    idx_q   <= IDX_TOP;
                    busy_q  <= 1'b1;
                    state_q <= TO_X;
                end
                TO_X: if (ack) begin
                    xm_q    <= prod;
                    state_q <= TO_ONE;
                end
                TO_ONE: if (ack) begin
                    acc_q   <= prod;
                    state_q <= SQR;
                end
                SQR: if (ack) begin
                    acc_q <= prod;
                    if (CONST_TIME || bit_set) state_q <= MUL;
                    else if (last_bit)         state_q <= FROM;
                    else begin
                        idx_q   <= idx_q - 1'b1;
                        state_q <= SQR;
                    end
                end
                MUL: if (ack) begin
                    // zero bits only reach here in the constant-time build; their product is dropped
                    if (bit_set) acc_q <= prod;
                    if (last_bit) state_q <= FROM;
                    else begin
                        idx_q   <= idx_q - 1'b1;
                        state_q <= SQR;
                    end
                end
                FROM: if (ack) begin
                    acc_q    <= prod;
                    result_q <= prod;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= FIN;
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign mm_n   = n_q;

endmodule
